lcd_hd44780_rx: RTL and testbench

Behavioural-synthesizable HD44780-compatible LCD controller. It is the receiving end of the 4-bit parallel bus (data[3:0], rs, rw, en) that the team's LCD drivers generate. It decodes the nibble stream into instructions and character writes, maintains DDRAM contents, cursor address and display flags, and models the busy flag. It sits in the FPGA test harness in place of a physical panel, so driver RTL can be checked on-chip and in simulation.

---
 rtl/lcd_hd44780_rx.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_hd44780_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_rx.sv
// HD44780-compatible panel model: decodes the 4/8-bit en-strobed bus into DDRAM writes, instructions and busy timing.
// Effects land one cycle after a sampled en fall; writes arriving while busy are dropped and flagged in proto_err.
module lcd_hd44780_rx #(
    parameter int BUSY_SHORT = 4000,
    parameter int BUSY_LONG  = 152000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] data,
    input  logic       rs,
    input  logic       rw,
    input  logic       en,
    output logic [3:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic [6:0] cursor_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       four_bit,
    output logic       two_line,
    output logic       proto_err,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char
);

    localparam int CW = $clog2(BUSY_LONG + 1);
    localparam logic [CW-1:0] SHORT_M1 = CW'(BUSY_SHORT - 1);
    localparam logic [CW-1:0] LONG_M1  = CW'(BUSY_LONG - 1);

    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    // Out-of-window set-address targets snap to the start of the next line.
    function automatic logic [6:0] map_set(input logic [6:0] a);
        if (a >= 7'h68) return 7'h00;
        if (a >= 7'h28 && a <= 7'h3F) return 7'h40;
        return a;
    endfunction

    function automatic logic [6:0] to_idx(input logic [6:0] a);
        return (a < 7'h40) ? a : a - 7'd24;
    endfunction

    function automatic logic in_map(input logic [6:0] a);
        return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
    endfunction

    logic          en_q;
    logic [3:0]    lat_data_q;
    logic          lat_rs_q;
    logic          lat_rw_q;
    logic          phase_q;
    logic [3:0]    hi_nib_q;
    logic          ev_vld_q;
    logic          ev_done_q;
    logic [7:0]    ev_byte_q;
    logic          ev_rs_q;
    logic          ev_rw_q;
    logic          busy_q;
    logic [CW-1:0] busy_cnt_q;
    logic [6:0]    cursor_q;
    logic          disp_on_q, cursor_on_q, blink_on_q;
    logic          inc_mode_q, four_bit_q, two_line_q, proto_err_q;
    logic [7:0]    ddram_q [80];
    logic [3:0]    data_out_q;
    logic          data_oe_q;
    logic [7:0]    rd_char_q;

    logic       fall;
    logic [7:0] byte_d;
    logic [6:0] cur_idx;
    logic [7:0] cur_char;

    assign fall     = en_q && !en;
    assign byte_d   = four_bit_q ? {hi_nib_q, lat_data_q} : {lat_data_q, 4'h0};
    assign cur_idx  = to_idx(cursor_q);
    assign cur_char = ddram_q[cur_idx];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lat_data_q <= '0;
            lat_rs_q   <= 1'b0;
            lat_rw_q   <= 1'b0;
        end else if (en) begin
            lat_data_q <= data;
            lat_rs_q   <= rs;
            lat_rw_q   <= rw;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            en_q        <= 1'b0;
            phase_q     <= 1'b1;
            hi_nib_q    <= '0;
            ev_vld_q    <= 1'b0;
            ev_done_q   <= 1'b0;
            ev_byte_q   <= '0;
            ev_rs_q     <= 1'b0;
            ev_rw_q     <= 1'b0;
            busy_q      <= 1'b0;
            busy_cnt_q  <= '0;
            cursor_q    <= '0;
            disp_on_q   <= 1'b0;
            cursor_on_q <= 1'b0;
            blink_on_q  <= 1'b0;
            inc_mode_q  <= 1'b1;
            four_bit_q  <= 1'b0;
            two_line_q  <= 1'b0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < 80; i++) ddram_q[i] <= 8'h20;
        end else begin
            en_q     <= en;
            ev_vld_q <= fall;
            // Phase keeps toggling on reads and busy-time writes so nibble pairing never slips.
            if (fall) begin
                ev_rs_q   <= lat_rs_q;
                ev_rw_q   <= lat_rw_q;
                ev_byte_q <= byte_d;
                ev_done_q <= !four_bit_q || !phase_q;
                if (four_bit_q) begin
                    phase_q <= ~phase_q;
                    if (phase_q) hi_nib_q <= lat_data_q;
                end
            end

            if (busy_q) begin
                if (busy_cnt_q == '0) busy_q <= 1'b0;
                else                  busy_cnt_q <= busy_cnt_q - 1'b1;
            end

            if (ev_vld_q) begin
                if (ev_rw_q) begin
                    if (ev_rs_q) begin
                        if (busy_q)         proto_err_q <= 1'b1;
                        else if (ev_done_q) cursor_q    <= step_addr(cursor_q, inc_mode_q);
                    end
                end else if (ev_done_q) begin
                    if (busy_q) begin
                        proto_err_q <= 1'b1;
                    end else begin
                        busy_q     <= 1'b1;
                        busy_cnt_q <= SHORT_M1;
                        if (ev_rs_q) begin
                            ddram_q[cur_idx] <= ev_byte_q;
                            cursor_q         <= step_addr(cursor_q, inc_mode_q);
                        end else if (ev_byte_q[7]) begin
                            cursor_q <= map_set(ev_byte_q[6:0]);
                        end else if (ev_byte_q[6]) begin
                            cursor_q <= cursor_q;
                        end else if (ev_byte_q[5]) begin
                            if (!ev_byte_q[4]) four_bit_q <= 1'b1;
                            two_line_q <= ev_byte_q[3];
                        end else if (ev_byte_q[4]) begin
                            if (!ev_byte_q[3]) cursor_q <= step_addr(cursor_q, ev_byte_q[2]);
                        end else if (ev_byte_q[3]) begin
                            disp_on_q   <= ev_byte_q[2];
                            cursor_on_q <= ev_byte_q[1];
                            blink_on_q  <= ev_byte_q[0];
                        end else if (ev_byte_q[2]) begin
                            inc_mode_q <= ev_byte_q[1];
                        end else if (ev_byte_q[1]) begin
                            cursor_q   <= '0;
                            busy_cnt_q <= LONG_M1;
                        end else if (ev_byte_q[0]) begin
                            for (int i = 0; i < 80; i++) ddram_q[i] <= 8'h20;
                            cursor_q   <= '0;
                            inc_mode_q <= 1'b1;
                            busy_cnt_q <= LONG_M1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            rd_char_q  <= 8'h20;
        end else begin
            rd_char_q <= in_map(rd_addr) ? ddram_q[to_idx(rd_addr)] : 8'h20;
            if (en && rw) begin
                data_oe_q <= 1'b1;
                if (!rs)         data_out_q <= phase_q ? {busy_q, cursor_q[6:4]} : cursor_q[3:0];
                else if (busy_q) data_out_q <= '0;
                else             data_out_q <= phase_q ? cur_char[7:4] : cur_char[3:0];
            end else begin
                data_oe_q  <= 1'b0;
                data_out_q <= '0;
            end
        end
    end

    assign data_out    = data_out_q;
    assign data_oe     = data_oe_q;
    assign busy        = busy_q;
    assign cursor_addr = cursor_q;
    assign disp_on     = disp_on_q;
    assign cursor_on   = cursor_on_q;
    assign blink_on    = blink_on_q;
    assign inc_mode    = inc_mode_q;
    assign four_bit    = four_bit_q;
    assign two_line    = two_line_q;
    assign proto_err   = proto_err_q;
    assign rd_char     = rd_char_q;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Directed bench for lcd_hd44780_rx: drives the nibble bus and compares flags, busy length and DDRAM against hand values.
module tb_lcd_hd44780_rx;

    localparam int BS = 8;
    localparam int BL = 32;

    logic       clk;
    logic       nrst;
    logic [3:0] data;
    logic       rs, rw, en;
    logic [3:0] data_out;
    logic       data_oe, busy;
    logic [6:0] cursor_addr;
    logic       disp_on, cursor_on, blink_on;
    logic       inc_mode, four_bit, two_line, proto_err;
    logic [6:0] rd_addr;
    logic [7:0] rd_char;

    int checks = 0;
    int errors = 0;

    lcd_hd44780_rx #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
        .clk(clk), .nrst(nrst), .data(data), .rs(rs), .rw(rw), .en(en),
        .data_out(data_out), .data_oe(data_oe), .busy(busy), .cursor_addr(cursor_addr),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .inc_mode(inc_mode), .four_bit(four_bit), .two_line(two_line),
        .proto_err(proto_err), .rd_addr(rd_addr), .rd_char(rd_char)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nib(input logic [3:0] d, input logic r, input logic w);
        @(negedge clk);
        data = d; rs = r; rw = w; en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic rd_nib(input logic r, output logic [3:0] v, output logic oe);
        @(negedge clk);
        rs = r; rw = 1'b1; en = 1'b1;
        @(negedge clk);
        v  = data_out;
        oe = data_oe;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rw = 1'b0;
    endtask

    task automatic count_busy(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < BL + 20; i++) begin
            if (busy) begin
                n++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [7:0] b, input logic r, output int n);
        nib(b[7:4], r, 1'b0);
        nib(b[3:0], r, 1'b0);
        count_busy(n);
    endtask

    task automatic peek(input logic [6:0] a, output logic [7:0] v);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        v = rd_char;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] c;
        logic [3:0] v;
        logic       oe;

        nrst = 1'b0; en = 1'b0; data = '0; rs = 1'b0; rw = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check_eq("rst_four_bit", four_bit, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cursor", cursor_addr, 0);
        check_eq("rst_inc", inc_mode, 1);
        check_eq("rst_dout", {data_oe, data_out}, 0);
        check_eq("rst_perr", proto_err, 0);
        check_eq("rst_rdchar", rd_char, 8'h20);

        // 8-bit wake-up sequence, then switch to 4-bit
        for (int i = 0; i < 4; i++) begin
            nib((i == 3) ? 4'h2 : 4'h3, 1'b0, 1'b0);
            count_busy(n);
            check_eq($sformatf("init_busy%0d", i), n, BS);
            check_eq($sformatf("init_4bit%0d", i), four_bit, (i == 3) ? 1 : 0);
        end
        check_eq("init_perr", proto_err, 0);

        wr(8'h80, 1'b0, n);
        wr(8'h48, 1'b1, n);
        check_eq("data_busy", n, BS);
        wr(8'h69, 1'b1, n);
        peek(7'h00, c); check_eq("ddram0", c, 8'h48);
        peek(7'h01, c); check_eq("ddram1", c, 8'h69);
        check_eq("cursor2", cursor_addr, 2);

        wr(8'h80, 1'b0, n);
        rd_nib(1'b1, v, oe);
        check_eq("rd_hi", v, 4'h4);
        check_eq("rd_oe", oe, 1);
        rd_nib(1'b1, v, oe);
        check_eq("rd_lo", v, 4'h8);
        check_eq("rd_step", cursor_addr, 1);
        check_eq("oe_clr", data_oe, 0);

        wr(8'hA7, 1'b0, n);
        check_eq("set_a7", cursor_addr, 7'h27);
        wr(8'h41, 1'b1, n);
        check_eq("wrap_27", cursor_addr, 7'h40);
        peek(7'h27, c); check_eq("ddram39", c, 8'h41);
        wr(8'h14, 1'b0, n);
        check_eq("shift_r", cursor_addr, 7'h41);

        wr(8'h04, 1'b0, n);
        check_eq("entry_dec", inc_mode, 0);
        wr(8'h80, 1'b0, n);
        wr(8'h5A, 1'b1, n);
        check_eq("wrap_00", cursor_addr, 7'h67);
        wr(8'h06, 1'b0, n);
        check_eq("entry_inc", inc_mode, 1);
        wr(8'hB0, 1'b0, n);
        check_eq("set_30", cursor_addr, 7'h40);
        peek(7'h30, c); check_eq("rd_hole", c, 8'h20);

        // return home, then write and read while it is still busy
        nib(4'h0, 1'b0, 1'b0);
        nib(4'h2, 1'b0, 1'b0);
        nib(4'h4, 1'b1, 1'b0);
        nib(4'h2, 1'b1, 1'b0);
        check_eq("busy_perr", proto_err, 1);
        rd_nib(1'b0, v, oe);
        check_eq("bf_hi", v[3], 1);
        rd_nib(1'b0, v, oe);
        check_eq("bf_lo", v, 0);
        check_eq("home_cursor", cursor_addr, 0);
        peek(7'h00, c); check_eq("busy_nowrite", c, 8'h5A);
        count_busy(n);

        wr(8'h04, 1'b0, n);
        wr(8'h01, 1'b0, n);
        check_eq("clr_busy", n, BL);
        check_eq("clr_cursor", cursor_addr, 0);
        check_eq("clr_inc", inc_mode, 1);
        peek(7'h00, c); check_eq("clr_idx0", c, 8'h20);
        peek(7'h67, c); check_eq("clr_idx79", c, 8'h20);
        peek(7'h27, c); check_eq("clr_idx39", c, 8'h20);

        wr(8'h0F, 1'b0, n);
        check_eq("dispctl", {disp_on, cursor_on, blink_on}, 3'b111);
        wr(8'h33, 1'b1, n);
        peek(7'h00, c); check_eq("pre_rst", c, 8'h33);

        // reset between the two nibbles of a set-address
        nib(4'h8, 1'b0, 1'b0);
        @(negedge clk);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mrst_4bit", four_bit, 0);
        check_eq("mrst_cursor", cursor_addr, 0);
        check_eq("mrst_flags", {disp_on, cursor_on, blink_on, inc_mode, two_line, proto_err, busy}, 7'b0001000);
        check_eq("mrst_dout", {data_oe, data_out}, 0);
        nrst = 1'b1;
        peek(7'h00, c); check_eq("mrst_ddram", c, 8'h20);
        nib(4'h2, 1'b0, 1'b0);
        count_busy(n);
        check_eq("mrst_8bit_busy", n, BS);
        check_eq("mrst_8bit_fs", four_bit, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
